// File: rtl/chroma_distortion_classifier.sv
// chroma_distortion_classifier
// Computes the normalised chromaticity distortion squared for one pixel,
// CD2 = sum over R,G,B of ((I - alpha*E)/sigma)^2, using one serial
// restoring divider shared by the three channels. It then classifies the
// pixel as BG/FG/SHADOW/HIGHLIGHT and presents the result on a
// valid/ready handshake.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a pixel; in_ready is high
// PREP   | form |I - alpha*E| for the current channel, load divider
// DIV    | 16 restoring-division steps, one quotient bit per cycle
// ACC    | add r*r into the accumulator, advance channel R->G->B
// CLASS  | compare against the captured thresholds, register result
// OUT    | hold result until out_ready, then clear and return to IDLE
module chroma_distortion_classifier #(
  parameter int TAG_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             in_ready,
  input  logic [7:0]       I_R,
  input  logic [7:0]       I_G,
  input  logic [7:0]       I_B,
  input  logic [15:0]      E_R,
  input  logic [15:0]      E_G,
  input  logic [15:0]      E_B,
  input  logic [15:0]      sigma_R,
  input  logic [15:0]      sigma_G,
  input  logic [15:0]      sigma_B,
  input  logic [31:0]      alpha,
  input  logic [TAG_W-1:0] tag_in,
  input  logic [31:0]      t_cd2,
  input  logic [31:0]      a_bg_lo,
  input  logic [31:0]      a_bg_hi,
  input  logic [31:0]      a_sh_min,
  output logic             valid_out,
  input  logic             out_ready,
  output logic [1:0]       pix_class,
  output logic [33:0]      cd2,
  output logic [TAG_W-1:0] tag_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_DIV, S_ACC, S_CLASS, S_OUT
  } state_t;

  localparam logic [1:0] CLS_BG = 2'b00;
  localparam logic [1:0] CLS_FG = 2'b01;
  localparam logic [1:0] CLS_SH = 2'b10;
  localparam logic [1:0] CLS_HL = 2'b11;

  state_t            state;
  logic [1:0]        ch;
  logic [3:0]        div_cnt;

  logic [7:0]        i_r_q, i_g_q, i_b_q;
  logic [15:0]       e_r_q, e_g_q, e_b_q;
  logic [15:0]       sg_r_q, sg_g_q, sg_b_q;
  logic [31:0]       alpha_q;
  logic [TAG_W-1:0]  tag_q;
  logic [31:0]       t_cd2_q, bg_lo_q, bg_hi_q, sh_min_q;

  logic [15:0]       s_q;
  logic              ovf_q;
  logic [15:0]       rem_q;
  logic [15:0]       dvd_q;
  logic [15:0]       quo_q;
  logic [33:0]       acc;

  // PREP datapath signals
  logic [7:0]        cur_i;
  logic [15:0]       cur_e, cur_sg, s_c, m_c;
  logic signed [48:0] prod, p_full;
  logic signed [49:0] d_c;
  logic [49:0]       d_abs;
  logic              ovf_c;

  // DIV / ACC / CLASS signals
  logic [16:0]       trial, diff;
  logic              ge;
  logic [15:0]       r_c;
  logic [31:0]       r_sq;
  logic [1:0]        cls_c;

  assign in_ready = (state == S_IDLE);

  // Channel select and |I - alpha*E| with saturation, plus overflow detect
  always_comb begin
    cur_i  = i_b_q;
    cur_e  = e_b_q;
    cur_sg = sg_b_q;
    case (ch)
      2'd0: begin cur_i = i_r_q; cur_e = e_r_q; cur_sg = sg_r_q; end
      2'd1: begin cur_i = i_g_q; cur_e = e_g_q; cur_sg = sg_g_q; end
      default: ;
    endcase
    s_c    = (cur_sg == 16'h0000) ? 16'h0001 : cur_sg;
    prod   = $signed({{17{alpha_q[31]}}, alpha_q}) * $signed({33'b0, cur_e});
    p_full = prod >>> 16;
    // 50 bits: the product term reaches 2^47, so the difference cannot wrap
    d_c    = $signed({34'b0, cur_i, 8'b0}) - $signed({p_full[48], p_full});
    d_abs  = d_c[49] ? 50'(-d_c) : 50'(d_c);
    m_c    = (|d_abs[49:16]) ? 16'hFFFF : d_abs[15:0];
    ovf_c  = ({8'b0, m_c} >= {s_c, 8'b0});
  end

  // One restoring-division step; the borrow bit is valid because rem < s
  always_comb begin
    trial = {rem_q, dvd_q[15]};
    diff  = trial - {1'b0, s_q};
    ge    = ~diff[16];
    r_c   = ovf_q ? 16'hFFFF : quo_q;
    r_sq  = {16'b0, r_c} * {16'b0, r_c};
  end

  // Classification in priority order: FG, BG, SHADOW, HIGHLIGHT
  always_comb begin
    if ((acc > {2'b0, t_cd2_q}) || ($signed(alpha_q) < $signed(sh_min_q)))
      cls_c = CLS_FG;
    else if (($signed(alpha_q) >= $signed(bg_lo_q)) &&
             ($signed(alpha_q) <= $signed(bg_hi_q)))
      cls_c = CLS_BG;
    else if ($signed(alpha_q) < $signed(bg_lo_q))
      cls_c = CLS_SH;
    else
      cls_c = CLS_HL;
  end

  // Control FSM with captured inputs, divider, accumulator and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ch        <= 2'd0;
      div_cnt   <= 4'd0;
      i_r_q     <= '0; i_g_q  <= '0; i_b_q  <= '0;
      e_r_q     <= '0; e_g_q  <= '0; e_b_q  <= '0;
      sg_r_q    <= '0; sg_g_q <= '0; sg_b_q <= '0;
      alpha_q   <= '0;
      tag_q     <= '0;
      t_cd2_q   <= '0; bg_lo_q <= '0; bg_hi_q <= '0; sh_min_q <= '0;
      s_q       <= '0;
      ovf_q     <= 1'b0;
      rem_q     <= '0;
      dvd_q     <= '0;
      quo_q     <= '0;
      acc       <= '0;
      valid_out <= 1'b0;
      pix_class <= CLS_BG;
      cd2       <= '0;
      tag_out   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_in) begin
            i_r_q    <= I_R;     i_g_q  <= I_G;     i_b_q  <= I_B;
            e_r_q    <= E_R;     e_g_q  <= E_G;     e_b_q  <= E_B;
            sg_r_q   <= sigma_R; sg_g_q <= sigma_G; sg_b_q <= sigma_B;
            alpha_q  <= alpha;
            tag_q    <= tag_in;
            t_cd2_q  <= t_cd2;
            bg_lo_q  <= a_bg_lo;
            bg_hi_q  <= a_bg_hi;
            sh_min_q <= a_sh_min;
            ch       <= 2'd0;
            state    <= S_PREP;
          end
        end
        S_PREP: begin
          // Dividend is m<<8: its top 8 bits seed the remainder
          s_q     <= s_c;
          ovf_q   <= ovf_c;
          rem_q   <= {8'b0, m_c[15:8]};
          dvd_q   <= {m_c[7:0], 8'h00};
          quo_q   <= '0;
          div_cnt <= 4'd15;
          state   <= S_DIV;
        end
        S_DIV: begin
          rem_q <= ge ? diff[15:0] : trial[15:0];
          quo_q <= {quo_q[14:0], ge};
          dvd_q <= {dvd_q[14:0], 1'b0};
          if (div_cnt == 4'd0)
            state <= S_ACC;
          else
            div_cnt <= div_cnt - 4'd1;
        end
        S_ACC: begin
          acc <= acc + {2'b0, r_sq};
          if (ch == 2'd2) begin
            state <= S_CLASS;
          end else begin
            ch    <= ch + 2'd1;
            state <= S_PREP;
          end
        end
        S_CLASS: begin
          pix_class <= cls_c;
          cd2       <= acc;
          tag_out   <= tag_q;
          valid_out <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            valid_out <= 1'b0;
            acc       <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
